// File: rtl/cram_bank_arb_if.sv
// cram_bank_arb_if
//   Bundles the two DMA CRAM master ports (m0 = read master, m1 = write
//   master) and the per-bank CRAM drive/return signals into one interface.
//   Signal names keep the arbiter's port naming; the _i/_o suffixes are
//   always seen from the arbiter's side.
//
//   Modports:
//     slave  - the arbiter itself (takes requests, drives banks)
//     master - the environment (DMA masters plus the CRAM banks)
//
//   Signals:
//     mK_cs_i      one-hot bank select, all-zero = idle
//     mK_wen_i     byte write enables, 0000 = read
//     mK_addr_i    byte address
//     mK_wdata_i   write data
//     mK_ready_o   request granted this cycle
//     mK_rdata_o   read data, nonzero only while mK_rvalid_o
//     mK_rvalid_o  read data valid (one cycle after a granted read)
//     bank_cs_o    per-bank chip select
//     bank_wen_o   per-bank byte enables, bank b at [4b+3:4b]
//     bank_addr_o  per-bank word address, bank b at [BANK_AW*b +: BANK_AW]
//     bank_wdata_o per-bank write data, bank b at [32b+31:32b]
//     bank_rdata_i per-bank read data, valid one cycle after a read CS
interface cram_bank_arb_if #(
  parameter int NB      = 4,
  parameter int BANK_AW = 8
);
  logic [NB-1:0]         m0_cs_i;
  logic [3:0]            m0_wen_i;
  logic [31:0]           m0_addr_i;
  logic [31:0]           m0_wdata_i;
  logic                  m0_ready_o;
  logic [31:0]           m0_rdata_o;
  logic                  m0_rvalid_o;

  logic [NB-1:0]         m1_cs_i;
  logic [3:0]            m1_wen_i;
  logic [31:0]           m1_addr_i;
  logic [31:0]           m1_wdata_i;
  logic                  m1_ready_o;
  logic [31:0]           m1_rdata_o;
  logic                  m1_rvalid_o;

  logic [NB-1:0]         bank_cs_o;
  logic [4*NB-1:0]       bank_wen_o;
  logic [BANK_AW*NB-1:0] bank_addr_o;
  logic [32*NB-1:0]      bank_wdata_o;
  logic [32*NB-1:0]      bank_rdata_i;

  modport slave (
    input  m0_cs_i, m0_wen_i, m0_addr_i, m0_wdata_i,
    output m0_ready_o, m0_rdata_o, m0_rvalid_o,
    input  m1_cs_i, m1_wen_i, m1_addr_i, m1_wdata_i,
    output m1_ready_o, m1_rdata_o, m1_rvalid_o,
    output bank_cs_o, bank_wen_o, bank_addr_o, bank_wdata_o,
    input  bank_rdata_i
  );

  modport master (
    output m0_cs_i, m0_wen_i, m0_addr_i, m0_wdata_i,
    input  m0_ready_o, m0_rdata_o, m0_rvalid_o,
    output m1_cs_i, m1_wen_i, m1_addr_i, m1_wdata_i,
    input  m1_ready_o, m1_rdata_o, m1_rvalid_o,
    input  bank_cs_o, bank_wen_o, bank_addr_o, bank_wdata_o,
    output bank_rdata_i
  );
endinterface

// File: rtl/cram_bank_arb.sv
// cram_bank_arb
//   Two-master to NB-bank CRAM arbiter sitting behind the DMA engine.
//   Each master targets the bank named by the lowest set bit of its CS.
//   Masters on different banks are both granted; on the same bank the
//   bank's round-robin pointer decides, and the pointer moves to the loser
//   after every conflict. Reads return one cycle after grant with a valid
//   strobe. A saturating counter records cycles with any bank conflict.
//
//   Ports:
//     clk_i          clock
//     rst_i          synchronous, active-low reset
//     bus            cram_bank_arb_if.slave (master requests, bank drive)
//     conflict_cnt_o saturating count of conflict cycles
module cram_bank_arb #(
  parameter int NB      = 4,
  parameter int BANK_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cram_bank_arb_if.slave      bus,
  output logic [CNT_W-1:0]    conflict_cnt_o
);

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [NB-1:0] sel0, sel1, both;
  logic [NB-1:0] ptr;          // 0 = m0 favoured, 1 = m1 favoured
  logic [NB-1:0] gbank0, gbank1;
  logic          grant0, grant1;
  logic [IW-1:0] idx0, idx1;
  logic [IW-1:0] rbank0, rbank1;
  logic          rvalid0, rvalid1;
  logic [CNT_W-1:0] cnt;

  function automatic logic [IW-1:0] encode(input logic [NB-1:0] onehot);
    logic [IW-1:0] idx;
    idx = '0;
    for (int b = 0; b < NB; b++)
      if (onehot[b]) idx = IW'(b);
    return idx;
  endfunction

  // x & -x isolates the lowest set bit, so a malformed CS still maps to one bank
  assign sel0 = bus.m0_cs_i & (-bus.m0_cs_i);
  assign sel1 = bus.m1_cs_i & (-bus.m1_cs_i);
  assign both = sel0 & sel1;
  assign idx0 = encode(sel0);
  assign idx1 = encode(sel1);

  // A master loses only if it shares a bank whose pointer favours the other
  assign grant0 = rst_i && (|sel0) && !(|(both & ptr));
  assign grant1 = rst_i && (|sel1) && !(|(both & ~ptr));
  assign gbank0 = grant0 ? sel0 : '0;
  assign gbank1 = grant1 ? sel1 : '0;

  assign bus.m0_ready_o = grant0;
  assign bus.m1_ready_o = grant1;

  // Granted banks take the winner's request; idle banks are driven to zero
  always_comb begin
    bus.bank_cs_o    = '0;
    bus.bank_wen_o   = '0;
    bus.bank_addr_o  = '0;
    bus.bank_wdata_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (gbank0[b]) begin
        bus.bank_cs_o[b]                     = 1'b1;
        bus.bank_wen_o[4*b +: 4]             = bus.m0_wen_i;
        bus.bank_addr_o[BANK_AW*b +: BANK_AW] = bus.m0_addr_i[BANK_AW+1:2];
        bus.bank_wdata_o[32*b +: 32]         = bus.m0_wdata_i;
      end else if (gbank1[b]) begin
        bus.bank_cs_o[b]                     = 1'b1;
        bus.bank_wen_o[4*b +: 4]             = bus.m1_wen_i;
        bus.bank_addr_o[BANK_AW*b +: BANK_AW] = bus.m1_addr_i[BANK_AW+1:2];
        bus.bank_wdata_o[32*b +: 32]         = bus.m1_wdata_i;
      end
    end
  end

  // Pointer flips on each conflicted bank, which hands it to the loser
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rbank0  <= '0;
      rbank1  <= '0;
      cnt     <= '0;
    end else begin
      ptr     <= ptr ^ both;
      rvalid0 <= grant0 && (bus.m0_wen_i == 4'b0000);
      rvalid1 <= grant1 && (bus.m1_wen_i == 4'b0000);
      if (grant0) rbank0 <= idx0;
      if (grant1) rbank1 <= idx1;
      if ((|both) && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.m0_rvalid_o = rvalid0;
  assign bus.m1_rvalid_o = rvalid1;
  assign bus.m0_rdata_o  = rvalid0 ? bus.bank_rdata_i[32*rbank0 +: 32] : 32'h0;
  assign bus.m1_rdata_o  = rvalid1 ? bus.bank_rdata_i[32*rbank1 +: 32] : 32'h0;
  assign conflict_cnt_o  = cnt;

endmodule

// File: tb/tb_cram_bank_arb.sv
// tb_cram_bank_arb
//   Self-checking bench for cram_bank_arb: a table of single-cycle vectors
//   with hand-computed grants, bank selects, counter and read returns,
//   followed by hand-written sequences for bank field routing, read latency,
//   back-to-back streaming and reset in mid-operation.
module tb_cram_bank_arb;

  logic        clk;
  logic        rst;
  logic [15:0] conflict_cnt;
  int          n_cmp;
  int          n_bad;

  cram_bank_arb_if #(.NB(4), .BANK_AW(8)) bus ();

  cram_bank_arb #(.NB(4), .BANK_AW(8), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus.slave),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cs0;
    logic [3:0]  wen0;
    logic [31:0] addr0;
    logic [3:0]  cs1;
    logic [3:0]  wen1;
    logic [31:0] addr1;
    logic        rdy0;
    logic        rdy1;
    logic [3:0]  bcs;
    logic [15:0] cnt;
    logic        rv0;
    logic        rv1;
    int          rb0;
    int          rb1;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] pat(input int b);
    return 32'hBBBB_0000 + b;
  endfunction

  function automatic vec_t mk(input logic [3:0] cs0, input logic [3:0] wen0,
                              input logic [31:0] addr0, input logic [3:0] cs1,
                              input logic [3:0] wen1, input logic [31:0] addr1,
                              input logic rdy0, input logic rdy1,
                              input logic [3:0] bcs, input logic [15:0] cnt,
                              input logic rv0, input logic rv1,
                              input int rb0, input int rb1);
    vec_t v;
    v.cs0 = cs0; v.wen0 = wen0; v.addr0 = addr0;
    v.cs1 = cs1; v.wen1 = wen1; v.addr1 = addr1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.bcs = bcs; v.cnt = cnt;
    v.rv0 = rv0; v.rv1 = rv1; v.rb0 = rb0; v.rb1 = rb1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] cs0, input logic [3:0] wen0,
                               input logic [31:0] addr0, input logic [31:0] wd0,
                               input logic [3:0] cs1, input logic [3:0] wen1,
                               input logic [31:0] addr1, input logic [31:0] wd1);
    bus.m0_cs_i = cs0; bus.m0_wen_i = wen0; bus.m0_addr_i = addr0; bus.m0_wdata_i = wd0;
    bus.m1_cs_i = cs1; bus.m1_wen_i = wen1; bus.m1_addr_i = addr1; bus.m1_wdata_i = wd1;
  endtask

  task automatic idle();
    applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus.bank_rdata_i = {pat(3), pat(2), pat(1), pat(0)};
    idle();

    // Reset state: requests present while reset is held must not get through
    @(negedge clk);
    applyStimulus(4'b0001, 4'hF, 32'h0, 32'h1, 4'b0010, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("rst ready0", 32'(bus.m0_ready_o), 32'd0);
    checkOutput("rst ready1", 32'(bus.m1_ready_o), 32'd0);
    checkOutput("rst bank_cs", 32'(bus.bank_cs_o), 32'd0);
    checkOutput("rst bank_wen", 32'(bus.bank_wen_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst rvalid0", 32'(bus.m0_rvalid_o), 32'd0);
    checkOutput("rst rvalid1", 32'(bus.m1_rvalid_o), 32'd0);
    checkOutput("rst cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Vectors applied back to back; pointer state carries from row to row
    vecs[0] = mk(4'b0001, 4'h0, 32'h014, 4'b0100, 4'hF, 32'h808, 1, 1, 4'b0101, 0, 1, 0, 0, 0);
    vecs[1] = mk(4'b0010, 4'h0, 32'h404, 4'b0010, 4'h0, 32'h408, 1, 0, 4'b0010, 1, 1, 0, 1, 0);
    vecs[2] = mk(4'b0010, 4'h0, 32'h404, 4'b0010, 4'h0, 32'h408, 0, 1, 4'b0010, 2, 0, 1, 0, 1);
    vecs[3] = mk(4'b0010, 4'h0, 32'h404, 4'b0010, 4'h0, 32'h408, 1, 0, 4'b0010, 3, 1, 0, 1, 0);
    vecs[4] = mk(4'b0000, 4'h0, 32'h000, 4'b0110, 4'hF, 32'h400, 0, 1, 4'b0010, 3, 0, 0, 0, 0);
    vecs[5] = mk(4'b0000, 4'h0, 32'h000, 4'b0000, 4'h0, 32'h000, 0, 0, 4'b0000, 3, 0, 0, 0, 0);
    vecs[6] = mk(4'b1000, 4'h3, 32'hC00, 4'b1000, 4'hC, 32'hC04, 1, 0, 4'b1000, 4, 0, 0, 0, 0);
    vecs[7] = mk(4'b0010, 4'h0, 32'h400, 4'b0001, 4'h0, 32'h000, 1, 1, 4'b0011, 4, 1, 1, 1, 0);
    vecs[8] = mk(4'b0010, 4'h0, 32'h400, 4'b0010, 4'h0, 32'h404, 0, 1, 4'b0010, 5, 0, 1, 0, 1);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].cs0, vecs[i].wen0, vecs[i].addr0, 32'hA0A0_0000 + i,
                    vecs[i].cs1, vecs[i].wen1, vecs[i].addr1, 32'hB1B1_0000 + i);
      #1;
      checkOutput($sformatf("v%0d ready0", i), 32'(bus.m0_ready_o), 32'(vecs[i].rdy0));
      checkOutput($sformatf("v%0d ready1", i), 32'(bus.m1_ready_o), 32'(vecs[i].rdy1));
      checkOutput($sformatf("v%0d bank_cs", i), 32'(bus.bank_cs_o), 32'(vecs[i].bcs));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d cnt", i), 32'(conflict_cnt), 32'(vecs[i].cnt));
      checkOutput($sformatf("v%0d rvalid0", i), 32'(bus.m0_rvalid_o), 32'(vecs[i].rv0));
      checkOutput($sformatf("v%0d rvalid1", i), 32'(bus.m1_rvalid_o), 32'(vecs[i].rv1));
      checkOutput($sformatf("v%0d rdata0", i), bus.m0_rdata_o,
                  vecs[i].rv0 ? pat(vecs[i].rb0) : 32'h0);
      checkOutput($sformatf("v%0d rdata1", i), bus.m1_rdata_o,
                  vecs[i].rv1 ? pat(vecs[i].rb1) : 32'h0);
    end

    // Parallel access: check per-bank routing of address, enables and data
    doReset();
    applyStimulus(4'b0001, 4'h0, 32'h014, 32'h0, 4'b0100, 4'hF, 32'h808, 32'hDEADBEEF);
    #1;
    checkOutput("par bank0 addr", 32'(bus.bank_addr_o[7:0]), 32'h05);
    checkOutput("par bank0 wen", 32'(bus.bank_wen_o[3:0]), 32'h0);
    checkOutput("par bank2 addr", 32'(bus.bank_addr_o[23:16]), 32'h02);
    checkOutput("par bank2 wen", 32'(bus.bank_wen_o[11:8]), 32'hF);
    checkOutput("par bank2 wdata", bus.bank_wdata_o[95:64], 32'hDEADBEEF);
    checkOutput("par bank1 idle", 32'(bus.bank_wen_o[7:4]) | 32'(bus.bank_addr_o[15:8]), 32'h0);
    @(posedge clk); #1;
    checkOutput("par rdata0", bus.m0_rdata_o, pat(0));

    // Read latency: bank3 data presented on the cycle after the grant
    @(negedge clk);
    applyStimulus(4'b1000, 4'h0, 32'hC04, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    checkOutput("lat bank3 addr", 32'(bus.bank_addr_o[31:24]), 32'h01);
    @(posedge clk);
    bus.bank_rdata_i[127:96] = 32'h12345678;
    #1;
    checkOutput("lat rvalid0", 32'(bus.m0_rvalid_o), 32'd1);
    checkOutput("lat rdata0", bus.m0_rdata_o, 32'h12345678);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    checkOutput("lat rvalid0 drop", 32'(bus.m0_rvalid_o), 32'd0);
    checkOutput("lat rdata0 drop", bus.m0_rdata_o, 32'h0);
    bus.bank_rdata_i[127:96] = pat(3);

    // Stream: four reads to banks 0..3 give continuous rvalid in order
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(4'(1 << i), 4'h0, 32'(i * 4), 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
      #1;
      checkOutput($sformatf("str%0d ready0", i), 32'(bus.m0_ready_o), 32'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("str%0d rvalid0", i), 32'(bus.m0_rvalid_o), 32'd1);
      checkOutput($sformatf("str%0d rdata0", i), bus.m0_rdata_o, pat(i));
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    checkOutput("str end rvalid0", 32'(bus.m0_rvalid_o), 32'd0);

    // Reset mid-operation: drops pending rvalid and clears pointers/counter
    @(negedge clk);
    applyStimulus(4'b0010, 4'h0, 32'h400, 32'h0, 4'b0010, 4'h0, 32'h404, 32'h0);
    @(posedge clk); #1;
    checkOutput("mid cnt", 32'(conflict_cnt), 32'd1);
    @(negedge clk);
    applyStimulus(4'b0001, 4'h0, 32'h000, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("mid rvalid0 set", 32'(bus.m0_rvalid_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0010, 4'h0, 32'h400, 32'h0, 4'b0010, 4'h0, 32'h404, 32'h0);
    #1;
    checkOutput("mid rst ready0", 32'(bus.m0_ready_o), 32'd0);
    checkOutput("mid rst ready1", 32'(bus.m1_ready_o), 32'd0);
    checkOutput("mid rst bank_cs", 32'(bus.bank_cs_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("mid rvalid0 drop", 32'(bus.m0_rvalid_o), 32'd0);
    checkOutput("mid rdata0 drop", bus.m0_rdata_o, 32'h0);
    checkOutput("mid cnt clear", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post ready0", 32'(bus.m0_ready_o), 32'd1);
    checkOutput("post ready1", 32'(bus.m1_ready_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("post cnt", 32'(conflict_cnt), 32'd1);
    @(negedge clk);
    idle();
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
